// File: rtl/fifo_stream_reader_pkg.sv
// Shared types for the FIFO stream reader: occupancy width and state encoding.
package fifo_stream_reader_pkg;

    localparam int OCC_WIDTH = 2;

    typedef enum logic [OCC_WIDTH-1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

endpackage

// File: rtl/fifo.sv
// Single-clock FIFO with registered read data and registered flags.
// Read data appears the cycle after rd_en_i is accepted.
module fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  full_o,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  empty_o,
    output logic [DEPTH_WIDTH:0]  count_o
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic [DEPTH_WIDTH:0]   count;
    logic                   do_wr;
    logic                   do_rd;

    // Accept writes only with space and reads only with data.
    always_comb begin
        do_wr   = wr_en_i & ~full_o;
        do_rd   = rd_en_i & ~empty_o;
        full_o  = (count == DEPTH[DEPTH_WIDTH:0]);
        empty_o = (count == '0);
        count_o = count;
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    // Pointers, occupancy and the registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data_o <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr    <= rd_ptr + 1'b1;
                rd_data_o <= mem[rd_ptr];
            end
            count <= count + {{DEPTH_WIDTH{1'b0}}, do_wr} - {{DEPTH_WIDTH{1'b0}}, do_rd};
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side adapter turning a registered-output FIFO into a registered
// valid/ready stream. A 2-entry buffer (head + skid) absorbs the one-cycle
// read latency so the stream sustains one word per cycle under backpressure.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [OCC_WIDTH-1:0]  level_o
);

    if (DATA_WIDTH <= 0) begin : g_width_check
        $error("fifo_stream_reader: DATA_WIDTH must be greater than zero");
    end

    occ_state_t            occ;
    occ_state_t            occ_next;
    logic                  inflight;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] out_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  pop;
    logic [2:0]            occ_sum;
    logic [OCC_WIDTH-1:0]  occ_after_pop;

    // Next occupancy and read issue: only issue when the word landing next
    // cycle is guaranteed a free buffer slot, counting the one already in flight.
    always_comb begin
        pop           = valid_q & m_ready_i;
        occ_sum       = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
        occ_after_pop = occ - {1'b0, pop};
        occ_next      = occ_state_t'(occ_sum[OCC_WIDTH-1:0]);
        fifo_rd_en_o  = ~rst & ~fifo_empty_i & (occ_sum <= 3'd1);
    end

    // Output buffer and occupancy FSM: skid advances on pop, a landing word
    // fills the head if the buffer drains this edge, otherwise the skid slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ      <= OCC_EMPTY;
            inflight <= 1'b0;
            valid_q  <= 1'b0;
            out_q    <= '0;
            skid_q   <= '0;
        end else begin
            inflight <= fifo_rd_en_o;
            occ      <= occ_next;
            valid_q  <= (occ_next != OCC_EMPTY);
            if (pop && (occ == OCC_TWO)) begin
                out_q <= skid_q;
            end
            if (inflight) begin
                if (occ_after_pop == '0) begin
                    out_q <= fifo_rd_data_i;
                end else begin
                    skid_q <= fifo_rd_data_i;
                end
            end
        end
    end

    // Registered state drives the stream outputs directly.
    always_comb begin
        m_data_o  = out_q;
        m_valid_o = valid_q;
        level_o   = occ;
    end

endmodule
